arb_rr4_dec_ctrl: RTL and testbench

- Round-robin arbiter and sequencer for one resource shared by 4 requesters.
- The resource is steered by a 2-to-4 decoder. This block generates the decoder's select and enable, and also exports the equivalent one-hot grant.
- It enforces a bounded hold time per grant and hands off back-to-back with no idle cycle.

---
 rtl/arb_rr4_dec_ctrl.sv | 117 +++++++++++
 tb/tb_arb_rr4_dec_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/arb_rr4_dec_ctrl.sv
// ---------------------------------------------------------------------------
// arb_rr4_dec_ctrl : 4-way round-robin arbiter driving a 2-to-4 decoder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_rr4_dec_ctrl #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] req_in,
  output logic [1:0] sel_out,
  output logic       en_out,
  output logic [3:0] gnt_out,
  output logic       busy_out,
  output logic       timeout_out
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold;
  logic [1:0]       r_sel;
  logic             r_en;
  logic [3:0]       r_gnt;
  logic             r_tmo;

  logic [3:0]       w_gmask;
  logic             w_drop;
  logic             w_tmo;
  logic [3:0]       w_cand;
  logic [1:0]       w_pick_idle;
  logic [1:0]       w_pick_rel;

  // First set bit of req scanning start, start+1, ... (mod 4).
  function automatic logic [1:0] f_pick(input logic [1:0] start, input logic [3:0] req);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    w_gmask     = 4'b0001 << r_sel;
    w_drop      = ~req_in[r_sel];
    w_tmo       = req_in[r_sel] && (r_hold == C_HOLD_LAST);
    // A timed-out holder stays eligible; scanning from g+1 makes it last.
    w_cand      = w_drop ? (req_in & ~w_gmask) : req_in;
    w_pick_idle = f_pick(r_ptr, req_in);
    w_pick_rel  = f_pick(r_sel + 2'd1, w_cand);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_hold  <= '0;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_gnt   <= 4'b0000;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_in != 4'b0000) begin
            r_sel   <= w_pick_idle;
            r_gnt   <= 4'b0001 << w_pick_idle;
            r_en    <= 1'b1;
            r_hold  <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_drop && !w_tmo) begin
            r_hold <= r_hold + C_CNT_ONE;
          end else begin
            r_ptr <= r_sel + 2'd1;
            r_tmo <= w_tmo;
            if (w_cand != 4'b0000) begin
              r_sel  <= w_pick_rel;
              r_gnt  <= 4'b0001 << w_pick_rel;
              r_hold <= '0;
            end else begin
              r_en    <= 1'b0;
              r_gnt   <= 4'b0000;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel_out     = r_sel;
  assign en_out      = r_en;
  assign gnt_out     = r_gnt;
  assign busy_out    = r_en;
  assign timeout_out = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr4_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb_rr4_dec_ctrl : directed bench for arb_rr4_dec_ctrl (MAX_HOLD 8/4/3).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arb_rr4_dec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req8 = '0, req4 = '0, req3 = '0;
  logic [1:0] sel8, sel4, sel3;
  logic       en8, en4, en3, busy8, busy4, busy3, tmo8, tmo4, tmo3;
  logic [3:0] gnt8, gnt4, gnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_rr4_dec_ctrl #(.MAX_HOLD(8), .CNT_W(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .req_in(req8), .sel_out(sel8), .en_out(en8),
    .gnt_out(gnt8), .busy_out(busy8), .timeout_out(tmo8));

  arb_rr4_dec_ctrl #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .req_in(req4), .sel_out(sel4), .en_out(en4),
    .gnt_out(gnt4), .busy_out(busy4), .timeout_out(tmo4));

  arb_rr4_dec_ctrl #(.MAX_HOLD(3), .CNT_W(8)) u_dut3 (
    .clk_in(clk), .rst_in(rst), .req_in(req3), .sel_out(sel3), .en_out(en3),
    .gnt_out(gnt3), .busy_out(busy3), .timeout_out(tmo3));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Compares a full output bundle against expected enable/select/timeout.
  task automatic check_dut(input string tag, input logic [1:0] o_sel, input logic o_en,
                           input logic [3:0] o_gnt, input logic o_busy, input logic o_tmo,
                           input logic e_en, input logic [1:0] e_sel, input logic e_tmo);
    logic [3:0] e_gnt;
    e_gnt = e_en ? (4'b0001 << e_sel) : 4'b0000;
    check_eq({tag, ".en"},   32'(o_en),   32'(e_en));
    check_eq({tag, ".sel"},  32'(o_sel),  32'(e_sel));
    check_eq({tag, ".gnt"},  32'(o_gnt),  32'(e_gnt));
    check_eq({tag, ".busy"}, 32'(o_busy), 32'(e_en));
    check_eq({tag, ".tmo"},  32'(o_tmo),  32'(e_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int g;
    // Reset and single request
    #1;
    rst = 1'b1;
    step();
    check_dut("rst_c1", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd0, 1'b0);
    step();
    check_dut("rst_c2", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd0, 1'b0);
    check_dut("rst_d4", sel4, en4, gnt4, busy4, tmo4, 1'b0, 2'd0, 1'b0);
    check_dut("rst_d3", sel3, en3, gnt3, busy3, tmo3, 1'b0, 2'd0, 1'b0);
    rst  = 1'b0;
    req8 = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check_dut("single", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd2, 1'b0);
    end
    req8 = 4'b0000;
    check_dut("tail", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd2, 1'b0);
    step();
    check_dut("single_rel", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd2, 1'b0);

    // Round-robin fairness with back-to-back handoffs
    do_reset();
    req8 = 4'b1111;
    step();
    check_dut("rr_first", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      req8 = 4'b1111;
      step();
      check_dut("rr_hold", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'(g), 1'b0);
      req8 = 4'b1111 & ~(4'b0001 << g);
      step();
      check_dut("rr_hand", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'((g + 1) % 4), 1'b0);
    end
    req8 = 4'b0000;
    step();

    // Timeout alternation, MAX_HOLD=4
    req4 = 4'b0011;
    for (int c = 1; c <= 17; c++) begin
      step();
      check_dut("tmo4", sel4, en4, gnt4, busy4, tmo4, 1'b1,
                2'(((c - 1) / 4) % 2), 1'((c > 1) && ((c - 1) % 4 == 0)));
    end
    req4 = 4'b0000;

    // Sole requester timeout, MAX_HOLD=3: pulses on cycles 4, 7, 10
    req3 = 4'b1000;
    for (int c = 1; c <= 10; c++) begin
      step();
      check_dut("sole3", sel3, en3, gnt3, busy3, tmo3, 1'b1, 2'd3,
                1'((c > 1) && ((c - 1) % 3 == 0)));
    end
    req3 = 4'b0000;

    // Pointer wrap and skip, no preemption mid-grant
    do_reset();
    req8 = 4'b1000;
    step();
    check_dut("wrap_g3", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd3, 1'b0);
    req8 = 4'b1101;
    step();
    check_dut("no_preempt", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd3, 1'b0);
    req8 = 4'b0101;
    step();
    check_dut("wrap_g0", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd0, 1'b0);
    step();
    check_dut("wrap_g0h", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd0, 1'b0);
    req8 = 4'b0100;
    step();
    check_dut("skip_g2", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd2, 1'b0);
    step();
    check_dut("skip_g2h", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd2, 1'b0);
    req8 = 4'b0000;
    step();
    check_dut("skip_idle", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd2, 1'b0);

    // Reset mid-grant with hold_cnt=2, then hold restarts
    do_reset();
    req8 = 4'b0010;
    for (int c = 0; c < 3; c++) step();
    check_dut("mid_pre", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd1, 1'b0);
    rst = 1'b1;
    step();
    check_dut("mid_rst", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check_dut("mid_regrant", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd1, 1'(c == 9));
    end

    // Reset clears the pointer: requester 0 wins over 1 afterwards
    req8 = 4'b0001;
    step();
    check_dut("ptr_h0", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd0, 1'b0);
    req8 = 4'b0000;
    step();
    check_dut("ptr_idle", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd0, 1'b0);
    req8 = 4'b0010;
    step();
    check_dut("ptr_g1", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd1, 1'b0);
    step();
    rst  = 1'b1;
    req8 = 4'b0011;
    step();
    check_dut("ptr_rst", sel8, en8, gnt8, busy8, tmo8, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check_dut("ptr_g0", sel8, en8, gnt8, busy8, tmo8, 1'b1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
